// File: rtl/pfb_multichannel_decimator_mul_pipe.sv
// Pipelined, clock-enabled multiplier for the PFB decimator datapath with valid/channel tracking.
// Optional round/saturate output scaling is enabled by defining PFB_MUL_ROUND_SAT_EN.
module pfb_multichannel_decimator_mul_pipe #(
   parameter int din0_WIDTH  = 14,
   parameter int din1_WIDTH  = 12,
   parameter int dout_WIDTH  = 26,
   parameter int din0_SIGNED = 0,
   parameter int din1_SIGNED = 0,
   parameter int NUM_STAGE   = 3,
   parameter int SHIFT       = 0,
   parameter int CHAN_WIDTH  = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  ce,
   input  logic                  in_valid,
   input  logic [din0_WIDTH-1:0] din0,
   input  logic [din1_WIDTH-1:0] din1,
   input  logic [CHAN_WIDTH-1:0] in_chan,
   output logic                  out_valid,
   output logic [dout_WIDTH-1:0] dout,
   output logic [CHAN_WIDTH-1:0] out_chan,
   output logic                  ovf
);
   localparam int P = din0_WIDTH + din1_WIDTH;

   if (NUM_STAGE < 1 || NUM_STAGE > 8 || SHIFT < 0 || SHIFT >= P) begin : g_bad_cfg
      $error("pfb_multichannel_decimator_mul_pipe: NUM_STAGE or SHIFT out of range");
   end

   // Operands get one extra bit so a single signed multiply covers every signedness mix.
   function automatic logic signed [P:0] mul(input logic [din0_WIDTH-1:0] a,
                                             input logic [din1_WIDTH-1:0] b);
      logic signed [din0_WIDTH:0] ax;
      logic signed [din1_WIDTH:0] bx;
      logic signed [P:0]          prod;
      ax   = {(din0_SIGNED != 0) && a[din0_WIDTH-1], a};
      bx   = {(din1_SIGNED != 0) && b[din1_WIDTH-1], b};
      prod = (P+1)'(ax) * (P+1)'(bx);
      return prod;
   endfunction

`ifdef PFB_MUL_ROUND_SAT_EN
   localparam int L      = (P + 2 > dout_WIDTH + 2) ? P + 2 : dout_WIDTH + 2;
   localparam bit RES_SIGNED = (din0_SIGNED != 0) || (din1_SIGNED != 0);
   localparam int RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;
   localparam logic signed [L-1:0] ONE  = L'(1);
   localparam logic signed [L-1:0] RND  = (SHIFT > 0) ? (ONE <<< RND_SH) : '0;
   localparam logic signed [L-1:0] MAXV = RES_SIGNED ? (ONE <<< (dout_WIDTH - 1)) - ONE
                                                     : (ONE <<< dout_WIDTH) - ONE;
   localparam logic signed [L-1:0] MINV = RES_SIGNED ? -(ONE <<< (dout_WIDTH - 1)) : '0;

   // Returns {ovf, dout}; unsigned products are non-negative in the extended form, so >>> is safe.
   function automatic logic [dout_WIDTH:0] scale(input logic signed [P:0] f);
      logic signed [L-1:0] r;
      r = (L'(f) + RND) >>> SHIFT;
      if (r > MAXV)      return {1'b1, MAXV[dout_WIDTH-1:0]};
      else if (r < MINV) return {1'b1, MINV[dout_WIDTH-1:0]};
      else               return {1'b0, r[dout_WIDTH-1:0]};
   endfunction
`else
   function automatic logic [dout_WIDTH:0] scale(input logic signed [P:0] f);
      return {1'b0, dout_WIDTH'(f)};
   endfunction
`endif

   logic signed [P:0]      fin_p;
   logic                   fin_v;
   logic [CHAN_WIDTH-1:0]  fin_c;

   if (NUM_STAGE == 1) begin : g_one
      assign fin_p = mul(din0, din1);
      assign fin_v = in_valid;
      assign fin_c = in_chan;
   end else begin : g_multi
      logic [din0_WIDTH-1:0] a_q;
      logic [din1_WIDTH-1:0] b_q;
      logic                  v1_q;
      logic [CHAN_WIDTH-1:0] c1_q;

      always_ff @(posedge clk) begin
         if (reset) begin
            a_q  <= '0;
            b_q  <= '0;
            v1_q <= 1'b0;
            c1_q <= '0;
         end else if (ce) begin
            a_q  <= din0;
            b_q  <= din1;
            v1_q <= in_valid;
            c1_q <= in_chan;
         end
      end

      if (NUM_STAGE == 2) begin : g_direct
         assign fin_p = mul(a_q, b_q);
         assign fin_v = v1_q;
         assign fin_c = c1_q;
      end else begin : g_prod_pipe
         logic signed [P:0]     p_q  [NUM_STAGE-2];
         logic                  pv_q [NUM_STAGE-2];
         logic [CHAN_WIDTH-1:0] pc_q [NUM_STAGE-2];

         always_ff @(posedge clk) begin
            if (reset) begin
               for (int i = 0; i < NUM_STAGE - 2; i++) begin
                  p_q[i]  <= '0;
                  pv_q[i] <= 1'b0;
                  pc_q[i] <= '0;
               end
            end else if (ce) begin
               p_q[0]  <= mul(a_q, b_q);
               pv_q[0] <= v1_q;
               pc_q[0] <= c1_q;
               for (int i = 1; i < NUM_STAGE - 2; i++) begin
                  p_q[i]  <= p_q[i-1];
                  pv_q[i] <= pv_q[i-1];
                  pc_q[i] <= pc_q[i-1];
               end
            end
         end

         assign fin_p = p_q[NUM_STAGE-3];
         assign fin_v = pv_q[NUM_STAGE-3];
         assign fin_c = pc_q[NUM_STAGE-3];
      end
   end

   logic [dout_WIDTH:0] scaled;
   assign scaled = scale(fin_p);

   // Output data and tag only move on valid samples so they hold across bubbles.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid <= 1'b0;
         dout      <= '0;
         out_chan  <= '0;
         ovf       <= 1'b0;
      end else if (ce) begin
         out_valid <= fin_v;
         ovf       <= fin_v & scaled[dout_WIDTH];
         if (fin_v) begin
            dout     <= scaled[dout_WIDTH-1:0];
            out_chan <= fin_c;
         end
      end
   end
endmodule

// File: tb/tb_pfb_multichannel_decimator_mul_pipe.sv
// Directed bench: default, signed-din0 and 16-bit/SHIFT=4 instances share one stimulus stream.
module tb_pfb_multichannel_decimator_mul_pipe;
   logic clk = 1'b0;
   logic reset, ce, in_valid;
   logic [13:0] din0;
   logic [11:0] din1;
   logic [3:0]  in_chan;

   logic ov0, ov1, ov2, ov3, of0, of1, of2, of3;
   logic [25:0] d0, d1;
   logic [15:0] d2, d3;
   logic [3:0]  oc0, oc1, oc2, oc3;

   int checks = 0;
   int passes = 0;
   int fails  = 0;

`ifdef PFB_MUL_ROUND_SAT_EN
   localparam logic [31:0] E1_D2 = 65535, E1_O2 = 1;
   localparam logic [31:0] E2_D2 = 65535, E2_O2 = 1;
   localparam logic [31:0] E2_D3 = 32768, E2_O3 = 1;
   localparam logic [31:0] E3_D2 = 19;
`else
   localparam logic [31:0] E1_D2 = 45057, E1_O2 = 0;
   localparam logic [31:0] E2_D2 = 57344, E2_O2 = 0;
   localparam logic [31:0] E2_D3 = 8192,  E2_O3 = 0;
   localparam logic [31:0] E3_D2 = 300;
`endif

   always #5 clk = ~clk;

   pfb_multichannel_decimator_mul_pipe u0 (
      .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .din0(din0), .din1(din1),
      .in_chan(in_chan), .out_valid(ov0), .dout(d0), .out_chan(oc0), .ovf(of0));

   pfb_multichannel_decimator_mul_pipe #(.din0_SIGNED(1)) u1 (
      .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .din0(din0), .din1(din1),
      .in_chan(in_chan), .out_valid(ov1), .dout(d1), .out_chan(oc1), .ovf(of1));

   pfb_multichannel_decimator_mul_pipe #(.dout_WIDTH(16), .SHIFT(4)) u2 (
      .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .din0(din0), .din1(din1),
      .in_chan(in_chan), .out_valid(ov2), .dout(d2), .out_chan(oc2), .ovf(of2));

   pfb_multichannel_decimator_mul_pipe #(.din0_SIGNED(1), .dout_WIDTH(16), .SHIFT(4)) u3 (
      .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .din0(din0), .din1(din1),
      .in_chan(in_chan), .out_valid(ov3), .dout(d3), .out_chan(oc3), .ovf(of3));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic [13:0] a, input logic [11:0] b, input logic [3:0] ch);
      din0     = a;
      din1     = b;
      in_chan  = ch;
      in_valid = 1'b1;
   endtask

   initial begin
      reset = 1'b1; ce = 1'b1; in_valid = 1'b0; din0 = '0; din1 = '0; in_chan = '0;
      tick();
      tick();
      check("rst_valid", 32'(ov0), 0);
      check("rst_dout",  32'(d0),  0);
      check("rst_chan",  32'(oc0), 0);
      check("rst_ovf",   32'(of0), 0);
      check("rst_dout16", 32'(d2), 0);
      reset = 1'b0;

      // Maximum unsigned operands, latency of 3
      issue(14'd16383, 12'd4095, 4'd5);
      tick();
      in_valid = 1'b0;
      check("max_lat1", 32'(ov0), 0);
      tick();
      check("max_lat2", 32'(ov0), 0);
      tick();
      check("max_valid", 32'(ov0), 1);
      check("max_dout",  32'(d0),  67088385);
      check("max_chan",  32'(oc0), 5);
      check("max_ovf",   32'(of0), 0);
      check("max_dout16", 32'(d2), E1_D2);
      check("max_ovf16",  32'(of2), E1_O2);
      tick();
      check("max_after_valid", 32'(ov0), 0);
      check("max_after_hold",  32'(d0),  67088385);
      check("max_after_ovf16", 32'(of2), 0);

      // Most negative signed din0
      issue(14'h2000, 12'd4095, 4'd9);
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      check("neg_valid",  32'(ov1), 1);
      check("neg_dout",   32'(d1),  32'h2002000);
      check("neg_chan",   32'(oc1), 9);
      check("neg_ovf",    32'(of1), 0);
      check("neg_udout",  32'(d0),  33546240);
      check("neg_dout16", 32'(d3),  E2_D3);
      check("neg_ovf16",  32'(of3), E2_O3);
      check("pos_dout16", 32'(d2),  E2_D2);
      check("pos_ovf16",  32'(of2), E2_O2);

      // Small product, rounding path
      issue(14'd100, 12'd3, 4'd2);
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      check("small_dout",   32'(d0),  300);
      check("small_dout16", 32'(d2),  E3_D2);
      check("small_ovf16",  32'(of2), 0);
      check("small_chan16", 32'(oc2), 2);

      // ce stall pattern 1,0,0,1,1
      issue(14'd7, 12'd11, 4'd3);
      tick();
      in_valid = 1'b0;
      ce = 1'b0;
      tick();
      check("stall_e2", 32'(ov0), 0);
      tick();
      check("stall_e3", 32'(ov0), 0);
      ce = 1'b1;
      tick();
      check("stall_e4", 32'(ov0), 0);
      tick();
      check("stall_valid", 32'(ov0), 1);
      check("stall_dout",  32'(d0),  77);
      check("stall_chan",  32'(oc0), 3);

      // Back-to-back channels 0..15
      for (int i = 0; i < 18; i++) begin
         if (i < 16) issue(14'(i + 1), 12'(i + 2), 4'(i));
         else in_valid = 1'b0;
         tick();
         if (i >= 2) begin
            check("b2b_valid", 32'(ov0), 1);
            check("b2b_chan",  32'(oc0), 32'(i - 2));
            check("b2b_dout",  32'(d0),  32'((i - 1) * i));
         end
      end
      tick();
      check("b2b_drain", 32'(ov0), 0);

      // Reset with samples in flight
      for (int k = 0; k < 3; k++) begin
         issue(14'(k + 2), 12'd3, 4'(k + 1));
         tick();
      end
      in_valid = 1'b0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("mrst_valid", 32'(ov0), 0);
      check("mrst_dout",  32'(d0),  0);
      check("mrst_chan",  32'(oc0), 0);
      for (int k = 0; k < 3; k++) begin
         tick();
         check("mrst_quiet", 32'(ov0), 0);
      end
      issue(14'd5, 12'd6, 4'd7);
      tick();
      in_valid = 1'b0;
      check("mrst_new_l1", 32'(ov0), 0);
      tick();
      check("mrst_new_l2", 32'(ov0), 0);
      tick();
      check("mrst_new_valid", 32'(ov0), 1);
      check("mrst_new_dout",  32'(d0),  30);
      check("mrst_new_chan",  32'(oc0), 7);
      tick();

      // Alternating bubbles
      for (int i = 0; i < 10; i++) begin
         if ((i % 2 == 0) && (i < 8)) issue(14'(i + 1), 12'd2, 4'(i));
         else begin
            din0 = 14'(i + 1); din1 = 12'd2; in_chan = 4'(i); in_valid = 1'b0;
         end
         tick();
         if (i >= 2) begin
            if ((i - 2) % 2 == 0) begin
               check("bub_valid", 32'(ov0), 1);
               check("bub_dout",  32'(d0),  32'((i - 1) * 2));
               check("bub_chan",  32'(oc0), 32'(i - 2));
            end else begin
               check("bub_gap",       32'(ov0), 0);
               check("bub_hold_dout", 32'(d0),  32'((i - 2) * 2));
               check("bub_hold_chan", 32'(oc0), 32'(i - 3));
            end
         end
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
